// File: rtl/wengine_multi.sv
// Message-schedule engine for SHA-1 / SHA-256: loads a 512-bit block and streams
// W[0..N-1] one word per accepted handshake using a sliding 16-word window.
module wengine_multi #(
   parameter int ENABLE_SHA256 = 1,
   parameter int ROUNDS_SHA1   = 80,
   parameter int ROUNDS_SHA256 = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [511:0] din,
   input  logic         mode,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic         abort,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  wout,
   output logic [6:0]   widx,
   output logic         done
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [6:0] LAST_SHA1   = 7'(ROUNDS_SHA1 - 1);
   localparam logic [6:0] LAST_SHA256 = 7'(ROUNDS_SHA256 - 1);

   state_t      state;
   logic [31:0] win [16];
   logic [6:0]  counter;
   logic        modeLatched;
   logic        doneReg;

   logic [31:0] sha1Word;
   logic [31:0] sha256Word;
   logic [31:0] newWord;
   logic [6:0]  lastIdx;
   logic        accept;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] smallSigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] smallSigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   assign load_ready = (state == IDLE);
   assign out_valid  = (state == RUN);
   assign wout       = win[0];
   assign widx       = counter;
   assign done       = doneReg;

   // Next schedule word for the active algorithm, plus the end-of-block index.
   always_comb begin
      sha1Word   = win[13] ^ win[8] ^ win[2] ^ win[0];
      sha1Word   = {sha1Word[30:0], sha1Word[31]};
      sha256Word = smallSigma1(win[14]) + win[9] + smallSigma0(win[1]) + win[0];
      newWord    = modeLatched ? sha256Word : sha1Word;
      lastIdx    = modeLatched ? LAST_SHA256 : LAST_SHA1;
      accept     = out_valid && out_ready;
   end

   // Abort outranks load and accept; only reset outranks abort.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         counter     <= '0;
         modeLatched <= 1'b0;
         doneReg     <= 1'b0;
         for (int i = 0; i < 16; i++) win[i] <= '0;
      end else begin
         doneReg <= 1'b0;
         if (abort) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (load_valid) begin
                     for (int i = 0; i < 16; i++) win[i] <= din[511 - 32*i -: 32];
                     counter     <= '0;
                     modeLatched <= (ENABLE_SHA256 != 0) && mode;
                     state       <= RUN;
                  end
               end
               RUN: begin
                  if (accept) begin
                     for (int i = 0; i < 15; i++) win[i] <= win[i + 1];
                     win[15] <= newWord;
                     counter <= counter + 7'd1;
                     if (counter == lastIdx) begin
                        state   <= IDLE;
                        doneReg <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
